// File: rtl/ow_slave_tx.sv
`default_nettype none
// ============================================================================
// Module      : ow_slave_tx
// Description : 1-Wire slave transmit engine. Emits presence pulses and
//               services master read slots by holding the bus low for a
//               read-0 or leaving it released for a read-1.
// Ports       :
//   clk           system clock, rising edge
//   nRst          asynchronous active-low reset
//   fall_pulse    one-cycle marker of a master-initiated bus falling edge
//   presence_req  one-cycle request to emit a presence pulse
//   tx_valid      a bit is offered for the next read slot
//   tx_bit        offered bit value
//   tx_ready      bit accepted this cycle when tx_valid is high
//   ow_drive_low  1 = pull bus low (open-drain), 0 = release
//   tx_done       one-cycle pulse, read slot serviced
//   pres_done     one-cycle pulse, presence pulse finished
//   busy          engine is not idle
// Revision    : 1.0 - initial release
// ============================================================================
module ow_slave_tx #(
   parameter int CNT_W   = 12,
   parameter int PDH_CYC = 300,
   parameter int PDL_CYC = 1200,
   parameter int RD0_CYC = 300
) (
   input  logic clk,
   input  logic nRst,
   input  logic fall_pulse,
   input  logic presence_req,
   input  logic tx_valid,
   input  logic tx_bit,
   output logic tx_ready,
   output logic ow_drive_low,
   output logic tx_done,
   output logic pres_done,
   output logic busy
);

   // Timer reload values: a state lasting N cycles loads N-1 and exits at 0.
   localparam logic [CNT_W-1:0] c_PDH_LOAD = CNT_W'(PDH_CYC - 1);
   localparam logic [CNT_W-1:0] c_PDL_LOAD = CNT_W'(PDL_CYC - 1);
   localparam logic [CNT_W-1:0] c_RD0_LOAD = CNT_W'(RD0_CYC - 1);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_PRES_WAIT = 3'd1,
      ST_PRES_LOW  = 3'd2,
      ST_ARMED     = 3'd3,
      ST_SLOT_LOW  = 3'd4
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_bit;
   logic             w_bit_nxt;
   logic             r_drive;
   logic             r_tx_done;
   logic             r_pres_done;
   logic             r_busy;
   logic             w_tx_done_nxt;
   logic             w_pres_done_nxt;
   logic             w_cnt_zero;

   assign w_cnt_zero = (r_cnt == '0);

   // presence_req masks acceptance so a simultaneous bit offer is refused.
   assign tx_ready = (r_state == ST_IDLE) && !presence_req;

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_bit       <= 1'b0;
         r_drive     <= 1'b0;
         r_tx_done   <= 1'b0;
         r_pres_done <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_bit       <= w_bit_nxt;
         // Outputs are decoded from the next state so they are registered
         // and line up exactly with the state they describe.
         r_drive     <= (w_state_nxt == ST_PRES_LOW) || (w_state_nxt == ST_SLOT_LOW);
         r_busy      <= (w_state_nxt != ST_IDLE);
         r_tx_done   <= w_tx_done_nxt;
         r_pres_done <= w_pres_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_bit_nxt       = r_bit;
      w_tx_done_nxt   = 1'b0;
      w_pres_done_nxt = 1'b0;

      if (presence_req) begin
         // Presence preempts everything; any armed bit is dropped silently.
         w_state_nxt = ST_PRES_WAIT;
         w_cnt_nxt   = c_PDH_LOAD;
         w_bit_nxt   = 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (tx_valid) begin
                  w_state_nxt = ST_ARMED;
                  w_bit_nxt   = tx_bit;
               end
            end
            ST_PRES_WAIT: begin
               if (w_cnt_zero) begin
                  w_state_nxt = ST_PRES_LOW;
                  w_cnt_nxt   = c_PDL_LOAD;
               end else begin
                  w_cnt_nxt = r_cnt - 1'b1;
               end
            end
            ST_PRES_LOW: begin
               if (w_cnt_zero) begin
                  w_state_nxt     = ST_IDLE;
                  w_pres_done_nxt = 1'b1;
               end else begin
                  w_cnt_nxt = r_cnt - 1'b1;
               end
            end
            ST_ARMED: begin
               if (fall_pulse) begin
                  if (!r_bit) begin
                     w_state_nxt = ST_SLOT_LOW;
                     w_cnt_nxt   = c_RD0_LOAD;
                  end else begin
                     // Read-1: the master's own release yields the 1.
                     w_state_nxt   = ST_IDLE;
                     w_tx_done_nxt = 1'b1;
                  end
               end
            end
            ST_SLOT_LOW: begin
               // fall_pulse is deliberately not looked at here.
               if (w_cnt_zero) begin
                  w_state_nxt   = ST_IDLE;
                  w_tx_done_nxt = 1'b1;
               end else begin
                  w_cnt_nxt = r_cnt - 1'b1;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   assign ow_drive_low = r_drive;
   assign tx_done      = r_tx_done;
   assign pres_done    = r_pres_done;
   assign busy         = r_busy;

endmodule
`default_nettype wire

// File: doc/ow_slave_tx.md
OW_SLAVE_TX -- requirements
Module: ow_slave_tx

Interface
REQ-001 The block SHALL have parameter CNT_W, default 12, meaning timer width in bits.
REQ-002 The block SHALL have parameter PDH_CYC, default 300, meaning presence wait-high time in clk cycles (30 us at 10 MHz).
REQ-003 The block SHALL have parameter PDL_CYC, default 1200, meaning presence low time in clk cycles (120 us).
REQ-004 The block SHALL have parameter RD0_CYC, default 300, meaning read-0 hold-low time in clk cycles (30 us).
REQ-005 clk  input  1  system clock, all logic on its rising edge.
REQ-006 nRst  input  1  reset, asynchronous, active-low.
REQ-007 fall_pulse  input  1  one-cycle pulse marking a master-initiated bus falling edge (already synchronised).
REQ-008 presence_req  input  1  one-cycle request to emit a presence pulse.
REQ-009 tx_valid  input  1  a bit is offered for the next master read slot.
REQ-010 tx_bit  input  1  bit value offered.
REQ-011 tx_ready  output  1  the block accepts a bit this cycle.
REQ-012 ow_drive_low  output  1  1 = pull bus low via open-drain, 0 = release.
REQ-013 tx_done  output  1  one-cycle pulse, read slot serviced.
REQ-014 pres_done  output  1  one-cycle pulse, presence pulse finished.
REQ-015 busy  output  1  state is not IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, PRES_WAIT, PRES_LOW, ARMED, SLOT_LOW.
REQ-017 tx_ready SHALL equal (state==IDLE) and not presence_req; a bit SHALL be accepted on a rising edge where tx_valid and tx_ready are both 1, latching tx_bit and entering ARMED.
REQ-018 presence_req SHALL have priority over everything: from any state, the next state SHALL be PRES_WAIT, any armed bit SHALL be discarded without tx_done, and ow_drive_low SHALL be 0 from the next edge.
REQ-019 PRES_WAIT SHALL hold ow_drive_low=0 for exactly PDH_CYC cycles, then enter PRES_LOW.
REQ-020 PRES_LOW SHALL hold ow_drive_low=1 for exactly PDL_CYC cycles, then enter IDLE with ow_drive_low=0 and pres_done=1 for that one cycle.
REQ-021 In ARMED, fall_pulse=1 with latched bit 0 SHALL enter SLOT_LOW; ow_drive_low SHALL be 1 from the next edge for exactly RD0_CYC cycles.
REQ-022 On leaving SLOT_LOW, the block SHALL enter IDLE with ow_drive_low=0 and tx_done=1 in the same cycle.
REQ-023 In ARMED, fall_pulse=1 with latched bit 1 SHALL enter IDLE on the next edge, with tx_done=1 for that cycle and ow_drive_low never asserted.
REQ-024 fall_pulse SHALL be ignored in every state except ARMED, including during SLOT_LOW.
REQ-025 The timer SHALL be a CNT_W-bit down-counter loaded with N-1 on state entry, where N is the duration; the state SHALL exit when the counter is 0.
REQ-026 All parameters SHALL be at least 1 and fit in CNT_W bits; other values SHALL be illegal and need no defined behaviour.
REQ-027 ow_drive_low, tx_done, pres_done and busy SHALL be registered outputs, free of glitches.
REQ-028 The block SHALL remain in ARMED indefinitely until fall_pulse or presence_req arrives; tx_valid SHALL be ignored while in ARMED.

Reset
REQ-029 While nRst=0, the state SHALL be IDLE, the counter and latched bit SHALL be 0, and ow_drive_low, tx_done, pres_done and busy SHALL all be 0, immediately and without waiting for clk.
REQ-030 Reset asserted mid-drive SHALL release the bus immediately; after deassertion, the block SHALL wait in IDLE and SHALL NOT resume the aborted operation.

Verification
REQ-031 Presence: presence_req pulse -> ow_drive_low 0 for 300 cycles, then 1 for 1200 cycles, then 0 with pres_done pulse; busy is 1 throughout.
REQ-032 Read 0: accept tx_bit=0, then fall_pulse -> ow_drive_low 1 from the next edge for exactly 300 cycles, then tx_done pulse and tx_ready=1.
REQ-033 Read 1: accept tx_bit=1, then fall_pulse -> ow_drive_low stays 0, tx_done one cycle later; a fall_pulse in IDLE produces no response.
REQ-034 Preemption: presence_req at cycle 100 of SLOT_LOW -> drive released next edge, no tx_done, full presence sequence follows; presence_req together with tx_valid in IDLE -> bit not accepted.
REQ-035 Reset: nRst low during PRES_LOW -> ow_drive_low 0 asynchronously, all outputs 0, IDLE after release.
REQ-036 Back-to-back: 8 bits 0,1,1,0,... each followed by fall_pulse -> drive pattern matches each bit; a fall_pulse during SLOT_LOW does not extend it.
